// File: rtl/axi_read_arbiter_pkg.sv
// Shared definitions for the AXI read arbiter and the data-side uncached
// interface: FSM state encoding, owner encoding and the default AXI IDs.
package axi_read_arbiter_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

    localparam logic [3:0] ID_I = 4'b0000;
    localparam logic [3:0] ID_D = 4'b0010;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    // Maps an owner bit to the AXI ID used on the shared channel.
    function automatic logic [3:0] owner_id(input logic owner);
        return owner ? ID_D : ID_I;
    endfunction

endpackage

// File: rtl/axi_read_arbiter_rr_pick2.sv
// Two-way round-robin selector: a lone requester wins outright, and on a
// tie the requester that did not win last time is chosen.
module rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic winner
);

    // Tie goes to the side other than last; otherwise whoever is asking.
    always_comb begin
        winner = req1;
        if (req0 && req1) begin
            winner = ~last;
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI read address/data channel pair between the instruction
// fetch and data access requesters. One transaction is outstanding at a
// time; read beats are steered combinationally back to the owner.
module axi_read_arbiter
    import axi_read_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst,

    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic [3:0]  i_len,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    output logic        i_rlast,

    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_len,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_rlast,

    output logic [3:0]  axim_arid,
    output logic [31:0] axim_araddr,
    output logic [3:0]  axim_arlen,
    output logic        axim_arvalid,
    input  logic        axim_arready,
    input  logic [3:0]  axim_rid,
    input  logic [31:0] axim_rdata,
    input  logic        axim_rlast,
    input  logic        axim_rvalid,
    output logic        axim_rready,

    output logic        err
);

    logic [1:0]  state;
    logic        owner;
    logic        last_owner;
    logic [31:0] addr;
    logic [3:0]  len;
    logic [3:0]  beats;
    logic        winner;
    logic        any_req;
    logic        beat;

    rr_pick2 u_pick (
        .req0   (i_req),
        .req1   (d_req),
        .last   (last_owner),
        .winner (winner)
    );

    assign any_req = i_req | d_req;

    // Transaction FSM: grant and latch in IDLE, hold the address until it is
    // accepted, then count beats until rlast returns us to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            owner      <= OWNER_I;
            last_owner <= OWNER_I;
            addr       <= 32'd0;
            len        <= 4'd0;
            beats      <= 4'd0;
            i_gnt      <= 1'b0;
            d_gnt      <= 1'b0;
        end else begin
            i_gnt <= 1'b0;
            d_gnt <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        owner      <= winner;
                        last_owner <= winner;
                        addr       <= winner ? d_addr : i_addr;
                        len        <= winner ? d_len : i_len;
                        beats      <= 4'd0;
                        i_gnt      <= ~winner;
                        d_gnt      <= winner;
                        state      <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    if (axim_arready) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (axim_rvalid) begin
                        beats <= beats + 4'd1;
                        if (axim_rlast) begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign axim_arvalid = (state == ST_ADDR);
    assign axim_araddr  = addr;
    assign axim_arlen   = len;
    assign axim_arid    = owner_id(owner);
    assign axim_rready  = 1'b1;

    assign beat = (state == ST_DATA) && axim_rvalid;

    // Steer each beat to the owning port only; the other port sees zeros.
    always_comb begin
        i_rvalid = 1'b0;
        i_rdata  = 32'd0;
        i_rlast  = 1'b0;
        d_rvalid = 1'b0;
        d_rdata  = 32'd0;
        d_rlast  = 1'b0;
        if (beat) begin
            if (owner == OWNER_D) begin
                d_rvalid = 1'b1;
                d_rdata  = axim_rdata;
                d_rlast  = axim_rlast;
            end else begin
                i_rvalid = 1'b1;
                i_rdata  = axim_rdata;
                i_rlast  = axim_rlast;
            end
        end
    end

    // Flag a wrong ID on any beat, or an rlast that arrives at the wrong count.
    always_comb begin
        err = 1'b0;
        if (beat) begin
            err = (axim_rid != owner_id(owner)) || (axim_rlast && (beats != len));
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter. A small AXI slave model drives
// read beats; each beat's expected routing is queued when driven and the
// captured port outputs are compared against it inside each scenario.
module tb_axi_read_arbiter;

    localparam logic [3:0] ID_I = 4'b0000;
    localparam logic [3:0] ID_D = 4'b0010;

    logic        clk;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [3:0]  i_len;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        i_rlast;
    logic        d_req;
    logic [31:0] d_addr;
    logic [3:0]  d_len;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_rlast;
    logic [3:0]  axim_arid;
    logic [31:0] axim_araddr;
    logic [3:0]  axim_arlen;
    logic        axim_arvalid;
    logic        axim_arready;
    logic [3:0]  axim_rid;
    logic [31:0] axim_rdata;
    logic        axim_rlast;
    logic        axim_rvalid;
    logic        axim_rready;
    logic        err;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct packed {
        logic        iv;
        logic        dv;
        logic [31:0] id;
        logic [31:0] dd;
        logic        il;
        logic        dl;
    } obs_t;

    beat_t sb[$];
    obs_t  obs_q[$];
    logic  gnt_log[$];
    int    err_cnt;
    int    compared;
    int    mismatched;

    axi_read_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .i_req        (i_req),
        .i_addr       (i_addr),
        .i_len        (i_len),
        .i_gnt        (i_gnt),
        .i_rvalid     (i_rvalid),
        .i_rdata      (i_rdata),
        .i_rlast      (i_rlast),
        .d_req        (d_req),
        .d_addr       (d_addr),
        .d_len        (d_len),
        .d_gnt        (d_gnt),
        .d_rvalid     (d_rvalid),
        .d_rdata      (d_rdata),
        .d_rlast      (d_rlast),
        .axim_arid    (axim_arid),
        .axim_araddr  (axim_araddr),
        .axim_arlen   (axim_arlen),
        .axim_arvalid (axim_arvalid),
        .axim_arready (axim_arready),
        .axim_rid     (axim_rid),
        .axim_rdata   (axim_rdata),
        .axim_rlast   (axim_rlast),
        .axim_rvalid  (axim_rvalid),
        .axim_rready  (axim_rready),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Records err pulses and grant pulses well after each rising edge.
    always begin
        @(posedge clk);
        #3;
        if (err === 1'b1) err_cnt++;
        if (i_gnt === 1'b1) gnt_log.push_back(1'b0);
        if (d_gnt === 1'b1) gnt_log.push_back(1'b1);
    end

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst          = 1'b1;
        i_req        = 1'b0;
        i_addr       = 32'd0;
        i_len        = 4'd0;
        d_req        = 1'b0;
        d_addr       = 32'd0;
        d_len        = 4'd0;
        axim_arready = 1'b0;
        axim_rid     = 4'd0;
        axim_rdata   = 32'd0;
        axim_rlast   = 1'b0;
        axim_rvalid  = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        step();
        err_cnt = 0;
        gnt_log.delete();
        sb.delete();
        obs_q.delete();
    endtask

    // Drives one R beat, queues where it should land and captures the ports.
    task automatic drive_beat(input logic [31:0] data, input logic last,
                              input logic [3:0] rid, input logic port);
        axim_rvalid = 1'b1;
        axim_rdata  = data;
        axim_rlast  = last;
        axim_rid    = rid;
        sb.push_back('{port, data, last});
        #1;
        obs_q.push_back('{i_rvalid, d_rvalid, i_rdata, d_rdata, i_rlast, d_rlast});
        step();
        axim_rvalid = 1'b0;
        axim_rlast  = 1'b0;
    endtask

    // Slave model: waits for arvalid, accepts after ar_wait cycles, returns nbeats.
    task automatic serve(input int ar_wait, input int nbeats, input logic gaps,
                         input logic [3:0] rid, input logic [31:0] base,
                         input logic port, output logic timeout);
        int n;
        timeout = 1'b0;
        n = 0;
        while (axim_arvalid !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        if (axim_arvalid !== 1'b1) begin
            timeout = 1'b1;
            return;
        end
        repeat (ar_wait) step();
        axim_arready = 1'b1;
        step();
        axim_arready = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            if (gaps && (b % 2 == 1)) step();
            drive_beat(base + 32'(b), (b == nbeats - 1), rid, port);
        end
    endtask

    task automatic wait_gnt(input logic port, output logic ok);
        int n;
        n = 0;
        ok = 1'b0;
        while (n < 20 && !ok) begin
            step();
            ok = port ? (d_gnt === 1'b1) : (i_gnt === 1'b1);
            n++;
        end
    endtask

    task automatic test_reset();
        beat_t e;
        apply_reset();
        compared++;
        if ({axim_arvalid, axim_araddr, axim_arlen, axim_arid} !== 41'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_ar: got arvalid=%b araddr=%h arlen=%h arid=%h, expected all zero",
                     axim_arvalid, axim_araddr, axim_arlen, axim_arid);
        end
        compared++;
        if ({i_gnt, d_gnt, err, i_rvalid, d_rvalid, i_rlast, d_rlast} !== 7'd0 ||
            i_rdata !== 32'd0 || d_rdata !== 32'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_ports: got gnt=%b%b err=%b rv=%b%b rl=%b%b idata=%h ddata=%h, expected zero",
                     i_gnt, d_gnt, err, i_rvalid, d_rvalid, i_rlast, d_rlast, i_rdata, d_rdata);
        end
        compared++;
        if (axim_rready !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL reset_rready: got %b expected 1", axim_rready);
        end
    endtask

    task automatic test_single_ifetch();
        beat_t e;
        obs_t  o;
        logic  to;
        apply_reset();
        i_addr = 32'h1FC0_0000;
        i_len  = 4'd0;
        i_req  = 1'b1;
        step();
        compared++;
        if ({i_gnt, d_gnt, axim_arvalid} !== 3'b101 || axim_arid !== ID_I ||
            axim_araddr !== 32'h1FC0_0000 || axim_arlen !== 4'd0) begin
            mismatched++;
            $display("[TB] FAIL single_grant: got gnt=%b%b arvalid=%b arid=%h araddr=%h arlen=%h, expected gnt=10 arvalid=1 arid=0 araddr=1fc00000 arlen=0",
                     i_gnt, d_gnt, axim_arvalid, axim_arid, axim_araddr, axim_arlen);
        end
        i_req  = 1'b0;
        i_addr = 32'h0000_0BAD;
        repeat (2) step();
        compared++;
        if (axim_arvalid !== 1'b1 || axim_araddr !== 32'h1FC0_0000 || i_gnt !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL single_ar_hold: got arvalid=%b araddr=%h i_gnt=%b, expected 1 1fc00000 0",
                     axim_arvalid, axim_araddr, i_gnt);
        end
        serve(0, 1, 1'b0, ID_I, 32'hDEAD_BEEF, 1'b0, to);
        compared++;
        if (to !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL single_timeout: arvalid never seen");
        end
        while (sb.size() > 0 && obs_q.size() > 0) begin
            e = sb.pop_front();
            o = obs_q.pop_front();
            compared++;
            if (o.iv !== !e.port || o.dv !== e.port || (e.port ? o.dd : o.id) !== e.data ||
                (e.port ? o.dl : o.il) !== e.last) begin
                mismatched++;
                $display("[TB] FAIL single_beat: got iv=%b dv=%b idata=%h ddata=%h il=%b dl=%b, expected port=%0d data=%h last=%b",
                         o.iv, o.dv, o.id, o.dd, o.il, o.dl, e.port, e.data, e.last);
            end
        end
        step();
        compared++;
        if (gnt_log.size() !== 1 || err_cnt !== 0) begin
            mismatched++;
            $display("[TB] FAIL single_pulses: got %0d grant cycles and %0d err, expected 1 and 0",
                     gnt_log.size(), err_cnt);
        end
    endtask

    task automatic test_simultaneous();
        beat_t e;
        obs_t  o;
        logic  to;
        apply_reset();
        i_addr = 32'h0000_1000;
        d_addr = 32'h8000_0040;
        i_req  = 1'b1;
        d_req  = 1'b1;
        step();
        compared++;
        if ({i_gnt, d_gnt} !== 2'b01 || axim_arid !== ID_D || axim_araddr !== 32'h8000_0040) begin
            mismatched++;
            $display("[TB] FAIL tie_first: got gnt=%b%b arid=%h araddr=%h, expected gnt=01 arid=2 araddr=80000040",
                     i_gnt, d_gnt, axim_arid, axim_araddr);
        end
        d_req = 1'b0;
        serve(1, 1, 1'b0, ID_D, 32'h1111_0000, 1'b1, to);
        compared++;
        if (to !== 1'b0 || axim_arvalid !== 1'b0 || i_gnt !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL tie_bubble: got timeout=%b arvalid=%b i_gnt=%b, expected 0 0 0",
                     to, axim_arvalid, i_gnt);
        end
        step();
        compared++;
        if (i_gnt !== 1'b1 || axim_arvalid !== 1'b1 || axim_arid !== ID_I || axim_araddr !== 32'h0000_1000) begin
            mismatched++;
            $display("[TB] FAIL tie_second: got i_gnt=%b arvalid=%b arid=%h araddr=%h, expected 1 1 0 00001000",
                     i_gnt, axim_arvalid, axim_arid, axim_araddr);
        end
        i_req = 1'b0;
        serve(0, 1, 1'b0, ID_I, 32'h2222_0000, 1'b0, to);
        while (sb.size() > 0 && obs_q.size() > 0) begin
            e = sb.pop_front();
            o = obs_q.pop_front();
            compared++;
            if (o.iv !== !e.port || o.dv !== e.port || (e.port ? o.dd : o.id) !== e.data ||
                (e.port ? o.dl : o.il) !== e.last) begin
                mismatched++;
                $display("[TB] FAIL tie_beat: got iv=%b dv=%b idata=%h ddata=%h il=%b dl=%b, expected port=%0d data=%h last=%b",
                         o.iv, o.dv, o.id, o.dd, o.il, o.dl, e.port, e.data, e.last);
            end
        end
    endtask

    task automatic test_round_robin();
        beat_t e;
        obs_t  o;
        logic  to;
        logic  exp_order[4];
        exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
        apply_reset();
        i_addr = 32'h0000_2000;
        d_addr = 32'h0000_3000;
        i_len  = 4'd1;
        d_len  = 4'd1;
        i_req  = 1'b1;
        d_req  = 1'b1;
        for (int t = 0; t < 4; t++) begin
            serve(t % 3, 2, 1'b0, exp_order[t] ? ID_D : ID_I, 32'(t) << 8, exp_order[t], to);
            compared++;
            if (to !== 1'b0) begin
                mismatched++;
                $display("[TB] FAIL rr_timeout: transaction %0d never issued", t);
            end
        end
        i_req = 1'b0;
        d_req = 1'b0;
        step();
        compared++;
        if (gnt_log.size() !== 4) begin
            mismatched++;
            $display("[TB] FAIL rr_count: got %0d grants expected 4", gnt_log.size());
        end
        for (int t = 0; t < 4 && gnt_log.size() > 0; t++) begin
            compared++;
            if (gnt_log[0] !== exp_order[t]) begin
                mismatched++;
                $display("[TB] FAIL rr_order: grant %0d got owner %0d expected %0d", t, gnt_log[0], exp_order[t]);
            end
            void'(gnt_log.pop_front());
        end
        while (sb.size() > 0 && obs_q.size() > 0) begin
            e = sb.pop_front();
            o = obs_q.pop_front();
            compared++;
            if (o.iv !== !e.port || o.dv !== e.port || (e.port ? o.dd : o.id) !== e.data ||
                (e.port ? o.dl : o.il) !== e.last) begin
                mismatched++;
                $display("[TB] FAIL rr_beat: got iv=%b dv=%b idata=%h ddata=%h il=%b dl=%b, expected port=%0d data=%h last=%b",
                         o.iv, o.dv, o.id, o.dd, o.il, o.dl, e.port, e.data, e.last);
            end
        end
        compared++;
        if (err_cnt !== 0) begin
            mismatched++;
            $display("[TB] FAIL rr_err: got %0d err pulses expected 0", err_cnt);
        end
    endtask

    task automatic test_burst();
        beat_t e;
        obs_t  o;
        logic  to;
        logic  ok;
        apply_reset();
        i_addr = 32'h0000_4000;
        i_len  = 4'd7;
        i_req  = 1'b1;
        wait_gnt(1'b0, ok);
        i_req = 1'b0;
        compared++;
        if (ok !== 1'b1 || axim_arlen !== 4'd7) begin
            mismatched++;
            $display("[TB] FAIL burst_grant: got granted=%b arlen=%h expected 1 7", ok, axim_arlen);
        end
        serve(1, 8, 1'b1, ID_I, 32'hA000_0000, 1'b0, to);
        step();
        compared++;
        if (sb.size() !== 8 || to !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL burst_len: got %0d beats timeout=%b expected 8 0", sb.size(), to);
        end
        while (sb.size() > 0 && obs_q.size() > 0) begin
            e = sb.pop_front();
            o = obs_q.pop_front();
            compared++;
            if (o.iv !== !e.port || o.dv !== e.port || (e.port ? o.dd : o.id) !== e.data ||
                (e.port ? o.dl : o.il) !== e.last) begin
                mismatched++;
                $display("[TB] FAIL burst_beat: got iv=%b dv=%b idata=%h ddata=%h il=%b dl=%b, expected port=%0d data=%h last=%b",
                         o.iv, o.dv, o.id, o.dd, o.il, o.dl, e.port, e.data, e.last);
            end
        end
        compared++;
        if (err_cnt !== 0) begin
            mismatched++;
            $display("[TB] FAIL burst_err: got %0d err pulses expected 0", err_cnt);
        end
    endtask

    task automatic test_errors();
        beat_t e;
        obs_t  o;
        logic  to;
        logic  ok;
        apply_reset();
        d_addr = 32'h0000_5000;
        d_len  = 4'd3;
        d_req  = 1'b1;
        wait_gnt(1'b1, ok);
        d_req = 1'b0;
        serve(0, 3, 1'b0, ID_D, 32'hC000_0000, 1'b1, to);
        step();
        compared++;
        if (err_cnt !== 1) begin
            mismatched++;
            $display("[TB] FAIL short_err: got %0d err pulses expected 1", err_cnt);
        end
        err_cnt = 0;
        i_addr = 32'h0000_6000;
        i_len  = 4'd0;
        i_req  = 1'b1;
        wait_gnt(1'b0, ok);
        i_req = 1'b0;
        compared++;
        if (ok !== 1'b1 || axim_arid !== ID_I) begin
            mismatched++;
            $display("[TB] FAIL after_err_grant: got granted=%b arid=%h expected 1 0", ok, axim_arid);
        end
        serve(0, 1, 1'b0, 4'hF, 32'hC100_0000, 1'b0, to);
        step();
        compared++;
        if (err_cnt !== 1) begin
            mismatched++;
            $display("[TB] FAIL rid_err: got %0d err pulses expected 1", err_cnt);
        end
        while (sb.size() > 0 && obs_q.size() > 0) begin
            e = sb.pop_front();
            o = obs_q.pop_front();
            compared++;
            if (o.iv !== !e.port || o.dv !== e.port || (e.port ? o.dd : o.id) !== e.data ||
                (e.port ? o.dl : o.il) !== e.last) begin
                mismatched++;
                $display("[TB] FAIL err_beat: got iv=%b dv=%b idata=%h ddata=%h il=%b dl=%b, expected port=%0d data=%h last=%b",
                         o.iv, o.dv, o.id, o.dd, o.il, o.dl, e.port, e.data, e.last);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        beat_t e;
        obs_t  o;
        logic  to;
        logic  ok;
        int    n;
        apply_reset();
        d_addr = 32'h0000_7000;
        d_len  = 4'd3;
        d_req  = 1'b1;
        wait_gnt(1'b1, ok);
        d_req = 1'b0;
        axim_arready = 1'b1;
        step();
        axim_arready = 1'b0;
        drive_beat(32'hE000_0000, 1'b0, ID_D, 1'b1);
        drive_beat(32'hE000_0001, 1'b0, ID_D, 1'b1);
        axim_rvalid = 1'b1;
        axim_rdata  = 32'hE000_0002;
        axim_rid    = ID_D;
        rst         = 1'b1;
        #1;
        compared++;
        if ({axim_arvalid, i_rvalid, d_rvalid, d_rlast, d_gnt} !== 5'd0 || d_rdata !== 32'd0 ||
            axim_araddr !== 32'd0) begin
            mismatched++;
            $display("[TB] FAIL midrst_outputs: got arvalid=%b rv=%b%b dl=%b dgnt=%b ddata=%h araddr=%h, expected zero",
                     axim_arvalid, i_rvalid, d_rvalid, d_rlast, d_gnt, d_rdata, axim_araddr);
        end
        step();
        axim_rvalid = 1'b0;
        rst         = 1'b0;
        d_addr      = 32'h0000_7100;
        d_len       = 4'd0;
        d_req       = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (d_gnt !== 1'b1 && n < 2);
        compared++;
        if (d_gnt !== 1'b1 || axim_arid !== ID_D || axim_araddr !== 32'h0000_7100) begin
            mismatched++;
            $display("[TB] FAIL midrst_regrant: got d_gnt=%b arid=%h araddr=%h, expected 1 2 00007100",
                     d_gnt, axim_arid, axim_araddr);
        end
        d_req = 1'b0;
        serve(0, 1, 1'b0, ID_D, 32'hE100_0000, 1'b1, to);
        while (sb.size() > 0 && obs_q.size() > 0) begin
            e = sb.pop_front();
            o = obs_q.pop_front();
            compared++;
            if (o.iv !== !e.port || o.dv !== e.port || (e.port ? o.dd : o.id) !== e.data ||
                (e.port ? o.dl : o.il) !== e.last) begin
                mismatched++;
                $display("[TB] FAIL midrst_beat: got iv=%b dv=%b idata=%h ddata=%h il=%b dl=%b, expected port=%0d data=%h last=%b",
                         o.iv, o.dv, o.id, o.dd, o.il, o.dl, e.port, e.data, e.last);
            end
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        err_cnt    = 0;
        test_reset();
        test_single_ifetch();
        test_simultaneous();
        test_round_robin();
        test_burst();
        test_errors();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/axi_read_arbiter.md
# axi_read_arbiter

Shares the single AXI read address/data channel pair between the instruction-fetch requester and the data-access requester of the CPU core. It sits between the core's two bus requesters and the AXI master port; write channels bypass it. One read transaction is outstanding at a time. Ownership alternates round-robin when both requesters are pending, and read data beats are routed back to the requester that owns the transaction.

## Interface
- `ID_I`, 4'b0000, `axim_arid` value for instruction transactions
- `ID_D`, 4'b0010, `axim_arid` value for data transactions
- `clk  in  1  system clock, all state on rising edge`
- `rst  in  1  reset, asynchronous, active-high`
- `i_req  in  1  instruction read request, level, held until i_gnt`
- `i_addr  in  32  instruction read address (word aligned)`
- `i_len  in  4  instruction burst length minus one (AXI arlen encoding)`
- `i_gnt  out  1  one-cycle pulse: instruction request accepted, addr/len latched`
- `i_rvalid  out  1  instruction read beat valid`
- `i_rdata  out  32  instruction read beat data`
- `i_rlast  out  1  last instruction beat`
- `d_req, d_addr, d_len, d_gnt, d_rvalid, d_rdata, d_rlast`: same widths and meanings for the data requester
- `axim_arid  out  4  ID_I or ID_D per owner`
- `axim_araddr  out  32  latched address`
- `axim_arlen  out  4  latched length`
- `axim_arvalid  out  1  address valid`
- `axim_arready  in  1  address accepted`
- `axim_rid  in  4  unused for routing; compared for error detection`
- `axim_rdata  in  32  read data`
- `axim_rlast  in  1  last beat`
- `axim_rvalid  in  1  beat valid`
- `axim_rready  out  1  tied 1`
- `err  out  1  one-cycle pulse on protocol mismatch (rid or beat count)`

## Operation
- State machine with three states: IDLE, ADDR, DATA. Registers: `owner` (0 = I, 1 = D), `last_owner`, latched `addr`/`len`, 4-bit beat counter `beats`.
- In IDLE, select the owner:
  - only one requester pending: grant it;
  - both pending: grant the requester other than `last_owner` (round-robin; `last_owner` resets to I, so D wins the first tie).
- Grant actions: pulse the winner's gnt, latch addr/len, set `owner` and `last_owner`, clear `beats`, go to ADDR.
- ADDR: drive `axim_arvalid`=1 with the latched fields. On `axim_arvalid && axim_arready`, go to DATA.
- DATA: on each `axim_rvalid`:
  - forward rdata/rlast to the owner's port only; the non-owner's rvalid stays 0;
  - increment `beats`.
- On `axim_rvalid && axim_rlast`, go to IDLE. If `beats != len` at the rlast beat, or `axim_rid` differs from the owner's ID on any beat, pulse `err`. The transaction still completes normally.
- A requester that drops req after gnt does not cancel the transaction; all beats are still delivered. Dropping req before gnt withdraws the request.
- If rlast never arrives, the block stays in DATA indefinitely. No timeout.

## Timing
- Reset values: `axim_arvalid`=0, `axim_araddr`=0, `axim_arlen`=0, `axim_arid`=0, gnts=0, `err`=0, per-port rvalid/rlast=0, rdata=0. State is IDLE, `last_owner`=I.
- gnt is a registered pulse, asserted in the cycle the FSM enters ADDR. `axim_arvalid` is also high from that cycle.
- Minimum latency: req sampled at edge N → gnt and arvalid high in cycle N+1. arvalid stays stable (no field changes) until arready.
- R path is combinational: `i_/d_rvalid`, rdata and rlast follow `axim_r*` in the same cycle, gated by `owner && state==DATA`.
- After the rlast beat, the FSM is in IDLE for one cycle, so back-to-back transactions have a one-cycle bubble between rlast and the next arvalid.
- Reset asserted mid-transaction returns all outputs to reset values immediately. Beats still in flight are not recovered.

## Structure
- Shared package: state encoding (IDLE=2'd0, ADDR=2'd1, DATA=2'd2) and the default IDs `ID_I`/`ID_D`, reused by the data-side uncached interface.
- One sub-module: `rr_pick2`, a combinational two-way round-robin selector with inputs req0, req1 and last, and output winner. Everything else is flat.

## Test plan
- Single instruction read (i_addr=0x1FC00000, i_len=0, arready after 2 cycles, one beat 0xDEADBEEF) → i_gnt one cycle; arid=0; i_rvalid/i_rlast with 0xDEADBEEF; d_rvalid stays 0.
- Simultaneous i_req and d_req out of reset → D granted first (arid=4'b0010); I granted after D's rlast with a one-cycle IDLE bubble.
- Both requesters continuously requesting, four transactions → grant order D, I, D, I.
- Instruction burst i_len=7, beats 0..7 with rvalid gaps → 8 beats routed, i_rlast only on the 8th, err=0.
- rlast on the 3rd beat with len=3 → err pulses once, FSM returns to IDLE, next request serviced.
- rst asserted while in DATA of a 4-beat burst → arvalid/rvalid outputs 0 immediately; after release, a new d_req gets d_gnt on the second cycle.
